mac_pe_seq_ctrl: RTL and testbench
==================================

Name: mac_pe_seq_ctrl

Overview:
Job sequencer for one signed_mac_dsp_88_18 PE (8x8 mode 0, 8x1-bit mode 1). Accepts a job (mode, length) and clears the PE accumulator. It then streams LEN operand pairs into the PE with valid/ready backpressure, aligning the PE `en` to the DSP multiplier latency. After the drain it captures the packed accumulator and hands it out over a valid/ready result port. It sits between the line-buffer/weight fetch logic and the PE array row.

Parameters:
MULT_LAT, 3, register stages of the DSP multiplier inside the PE (operand in -> product out)
LEN_W, 16, width of job length field
PE_OUT_W, 56, width of the PE accumulator output (4 lanes x 14 bits)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
start  input  1  job request; accepted only in IDLE
cfg_mode  input  1  0 = 8b x 8b (2 lanes x 20b), 1 = 8b x 1b (4 lanes x 14b)
cfg_len  input  LEN_W  number of operand pairs in the job
busy  output  1  high in any state except IDLE
in_valid  input  1  operand pair valid
in_ready  output  1  controller accepts operand pair
in_a  input  16  two packed signed int8 pixels {hi, lo}
in_b  input  8  mode 0: signed int8 weight; mode 1: bits[1:0] = 1-bit weights (0 = +1, 1 = -1)
pe_clear  output  1  drives PE reset
pe_en  output  1  drives PE en
pe_mode  output  1  drives PE mode
pe_a  output  16  drives PE I_A
pe_b  output  8  drives PE I_B
pe_o  input  PE_OUT_W  PE accumulator O
res_valid  output  1  result available
res_ready  input  1  result consumer ready
res_data  output  PE_OUT_W  captured accumulator
done  output  1  one-cycle pulse when the result handshake completes

Behaviour:
- Reset (any state, including mid-job): state=IDLE, counters=0, valid shift register=0, pe_en=0, res_valid=0, done=0, pe_a=0, pe_b=0, pe_mode=0, res_data=0. pe_clear = reset OR (state==CLEAR), combinational. In-flight operands are discarded.
- States: IDLE -> CLEAR -> FEED -> DRAIN -> RESULT -> IDLE.
- IDLE: start=1 latches cfg_mode into pe_mode and cfg_len into len_r, then goes to CLEAR. start in any other state is ignored.
- CLEAR: lasts 1 cycle with pe_clear=1 and in_ready=0. Next state is FEED, or DRAIN when len_r==0.
- FEED: in_ready=1 while issued<len_r.
  - Each handshake (in_valid & in_ready) registers in_a/in_b into pe_a/pe_b, increments issued, and pushes 1 into a MULT_LAT-deep valid shift register. Non-handshake cycles push 0.
  - pe_a/pe_b hold their last value when there is no handshake.
  - The handshake after which issued==len_r moves the FSM to DRAIN.
- pe_en = tail of the valid shift register. For a handshake in cycle n: pe_a/pe_b are driven in n+1 and pe_en is high in n+1+MULT_LAT (n+4 at default). Exactly len_r pe_en pulses occur per job.
- Bubbles (in_valid low) produce pe_en-low cycles, and the PE holds O.
- pe_mode is constant from CLEAR until the next accepted start. Mode never changes while products are in flight.
- DRAIN: waits until the shift register is empty and the en count equals len_r, plus 1 cycle for pe_o to settle. It then captures pe_o into res_data and moves to RESULT. For a final handshake in cycle n, res_valid rises in cycle n+MULT_LAT+3.
- RESULT: res_valid=1 and res_data is stable until res_ready=1. The handshake cycle asserts done for 1 cycle in the following cycle and returns to IDLE. res_ready high in the first RESULT cycle completes immediately.
- A new start may be accepted in the cycle IDLE is re-entered.
- With len_r==0, the result is all zeros (PE cleared, no en).
- Width rules: issued and en counters are LEN_W bits with no wrap; the maximum job is 2^LEN_W-1 pairs. Lane overflow is the PE's headroom concern, not the controller's.

Test Plan:
1. Mode 0, len=4, every pair in_a={8'd3,8'd2} and in_b=8'd5, in_valid held high. Required: exactly 4 pe_en pulses, pe_en first high 4 cycles after the first handshake, res_data[19:0]=40, res_data[39:20]=60, res_data[55:40]=0, then a done pulse.
2. Mode 1, len=3, in_a={8'd10,-8'd4}, in_b=8'b01. Required: 14-bit lanes lane0=12, lane1=-30, lane2=-12, lane3=30.
3. Backpressure with mode 0 and len=5: in_valid toggled 1,0,0,1,1,0,1,1 and res_ready held low 4 cycles. Required: 5 pe_en pulses with gaps matching the bubbles, the correct sum, res_data stable while res_valid=1 and res_ready=0, and done exactly once.
4. len=0 job. Required: pe_clear for 1 cycle, no in_ready and no pe_en, res_data=0, res_valid asserted.
5. start pulsed during FEED of a len=6 job. Required: the second start is ignored and the first job completes unchanged. A start asserted in the cycle after done is accepted.
6. reset asserted in DRAIN with 2 products in flight. Required: the next cycle shows IDLE, pe_en=0, res_valid=0, and pe_clear was high during reset. A fresh len=2 job then returns only its own sum.

Source files
------------

// File: rtl/mac_pe_seq_ctrl.sv
// mac_pe_seq_ctrl: job sequencer feeding one MAC PE and returning its packed accumulator
module mac_pe_seq_ctrl #(
  parameter int MULT_LAT = 3,
  parameter int LEN_W    = 16,
  parameter int PE_OUT_W = 56
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cfg_mode,
  input  logic [LEN_W-1:0]    cfg_len,
  output logic                busy,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_a,
  input  logic [7:0]          in_b,
  output logic                pe_clear,
  output logic                pe_en,
  output logic                pe_mode,
  output logic [15:0]         pe_a,
  output logic [7:0]          pe_b,
  input  logic [PE_OUT_W-1:0] pe_o,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [PE_OUT_W-1:0] res_data,
  output logic                done
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_RESULT} state_t;
  state_t            r_state, w_next;
  logic [LEN_W-1:0]  r_len, r_issued, r_en_cnt;
  logic [MULT_LAT:0] r_vsr;
  logic              w_hs, w_drained;
  assign busy      = r_state != S_IDLE;
  assign in_ready  = r_state == S_FEED && r_issued < r_len;
  assign w_hs      = in_valid & in_ready;
  assign pe_clear  = reset | (r_state == S_CLEAR);
  // one extra stage beyond the multiplier depth accounts for the operand register
  assign pe_en     = r_vsr[MULT_LAT];
  assign res_valid = r_state == S_RESULT;
  assign w_drained = r_vsr == '0 && r_en_cnt == r_len;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   w_next = start ? S_CLEAR : S_IDLE;
      S_CLEAR:  w_next = r_len == '0 ? S_DRAIN : S_FEED;
      S_FEED:   w_next = w_hs && (r_issued + LEN_W'(1)) == r_len ? S_DRAIN : S_FEED;
      S_DRAIN:  w_next = w_drained ? S_RESULT : S_DRAIN;
      S_RESULT: w_next = res_ready ? S_IDLE : S_RESULT;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_issued <= '0;
      r_en_cnt <= '0;
      r_vsr    <= '0;
      pe_mode  <= 1'b0;
      pe_a     <= '0;
      pe_b     <= '0;
      res_data <= '0;
      done     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_vsr   <= {r_vsr[MULT_LAT-1:0], w_hs};
      done    <= res_valid & res_ready;
      if (w_hs) begin
        pe_a     <= in_a;
        pe_b     <= in_b;
        r_issued <= r_issued + LEN_W'(1);
      end
      if (pe_en) r_en_cnt <= r_en_cnt + LEN_W'(1);
      // pe_o has had a full cycle to absorb the last enabled product
      if (r_state == S_DRAIN && w_drained) res_data <= pe_o;
      if (r_state == S_IDLE && start) begin
        r_len    <= cfg_len;
        pe_mode  <= cfg_mode;
        r_issued <= '0;
        r_en_cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mac_pe_seq_ctrl.sv
// tb_mac_pe_seq_ctrl: randomized scoreboard bench with a behavioural PE and job-level reference
module tb_mac_pe_seq_ctrl;
  logic        clk = 0, reset = 1, start = 0, cfg_mode = 0, in_valid = 0, res_ready = 0;
  logic [15:0] cfg_len = 0, in_a = 0;
  logic [7:0]  in_b = 0;
  logic        busy, in_ready, pe_clear, pe_en, pe_mode, res_valid, done;
  logic [15:0] pe_a;
  logic [7:0]  pe_b;
  logic [55:0] pe_o, res_data;

  mac_pe_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .pe_clear(pe_clear), .pe_en(pe_en), .pe_mode(pe_mode), .pe_a(pe_a), .pe_b(pe_b),
    .pe_o(pe_o), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  function automatic int prod(input bit m, input logic [15:0] a, input logic [7:0] b, input int k);
    int lo, hi, w, w0, w1;
    lo = int'($signed(a[7:0]));
    hi = int'($signed(a[15:8]));
    w  = int'($signed(b));
    w0 = b[0] ? -1 : 1;
    w1 = b[1] ? -1 : 1;
    if (!m) return k == 0 ? lo * w : k == 1 ? hi * w : 0;
    return k == 0 ? lo * w0 : k == 1 ? hi * w0 : k == 2 ? lo * w1 : hi * w1;
  endfunction

  function automatic logic [55:0] pack(input bit m, input int l0, input int l1, input int l2, input int l3);
    return m ? {14'(l3), 14'(l2), 14'(l1), 14'(l0)} : {16'd0, 20'(l1), 20'(l0)};
  endfunction

  // stand-in PE: 3-stage multiplier pipeline, accumulate on en, cleared by pe_clear
  logic [15:0] pa[3];
  logic [7:0]  pb[3];
  int          acc[4];
  always @(posedge clk) begin
    if (pe_clear) begin
      for (int k = 0; k < 4; k++) acc[k] <= 0;
      for (int k = 0; k < 3; k++) begin pa[k] <= '0; pb[k] <= '0; end
    end else begin
      if (pe_en) for (int k = 0; k < 4; k++) acc[k] <= acc[k] + prod(pe_mode, pa[2], pb[2], k);
      pa[0] <= pe_a; pa[1] <= pa[0]; pa[2] <= pa[1];
      pb[0] <= pe_b; pb[1] <= pb[0]; pb[2] <= pb[1];
    end
  end
  assign pe_o = pack(pe_mode, acc[0], acc[1], acc[2], acc[3]);

  logic [15:0] a_arr[64];
  logic [7:0]  b_arr[64];
  bit          pat[8] = '{1, 0, 0, 1, 1, 0, 1, 1};

  function automatic logic [55:0] ref_job(input bit m, input int len);
    int l[4] = '{default: 0};
    for (int i = 0; i < len; i++)
      for (int k = 0; k < 4; k++) l[k] += prod(m, a_arr[i], b_arr[i], k);
    return pack(m, l[0], l[1], l[2], l[3]);
  endfunction

  task automatic fill(input int len);
    for (int i = 0; i < len; i++) begin
      a_arr[i] = 16'($urandom);
      b_arr[i] = 8'($urandom);
    end
  endtask

  logic [55:0] sb[$];
  int          en_q[$];
  int          exp_rv = -1, done_exp = -1, cur_len = 0, clr_cnt = 0, rdy_cnt = 0;
  logic        prev_rv = 0;
  logic [55:0] held;

  always @(negedge clk) begin
    if (reset) begin
      chk("pe_clear_in_reset", 64'(pe_clear), 64'd1);
      sb.delete(); en_q.delete();
      exp_rv = -1; done_exp = -1; prev_rv = 0; clr_cnt = 0; rdy_cnt = 0;
    end else begin
      if (pe_clear) clr_cnt++;
      if (in_ready) rdy_cnt++;
      if (in_valid && in_ready) en_q.push_back(cyc + 4);
      if (pe_en) begin
        if (en_q.size() == 0) chk("pe_en_unexpected", 64'(pe_en), 64'd0);
        else chk("pe_en_cycle", 64'(cyc), 64'(en_q.pop_front()));
      end
      if (res_valid && !prev_rv) begin
        chk("res_valid_rise", 64'(cyc), 64'(exp_rv));
        held = res_data;
      end
      if (res_valid && prev_rv) chk("res_data_stable", 64'(res_data), 64'(held));
      if (res_valid && res_ready) begin
        if (sb.size() == 0) chk("res_unexpected", 64'(res_valid), 64'd0);
        else chk("res_data", 64'(res_data), 64'(sb.pop_front()));
        chk("en_count", 64'(en_q.size()), 64'd0);
        chk("clear_cycles", 64'(clr_cnt), 64'd1);
        if (cur_len == 0) chk("len0_no_ready", 64'(rdy_cnt), 64'd0);
        clr_cnt = 0; rdy_cnt = 0;
        done_exp = cyc + 1;
      end
      if (done || cyc == done_exp) chk("done_pulse", 64'(done), 64'(cyc == done_exp));
      prev_rv = res_valid;
    end
  end

  task automatic run_job(input bit mode, input int len, input int vmode, input int stall,
                         input bit mid_start, input bit rst_drain);
    int idx, t, sc, guard;
    @(posedge clk); #1;
    res_ready = 0; start = 1; cfg_mode = mode; cfg_len = 16'(len);
    guard = 0;
    forever begin
      @(negedge clk);
      if (!busy) break;
      guard++;
      if (guard > 200) begin
        chk("start_timeout", 64'(busy), 64'd0);
        start = 0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("start_accept_delay", 64'(guard), 64'd0);
    sb.push_back(ref_job(mode, len));
    cur_len = len;
    if (len == 0) exp_rv = cyc + 3;
    idx = 0; t = 0;
    while (idx < len) begin
      @(posedge clk); #1;
      start = mid_start && t == 3;
      if (mid_start) begin cfg_mode = ~mode; cfg_len = 16'd2; end
      in_valid = vmode == 0 ? 1'b1 : vmode == 2 ? pat[t % 8] : ($urandom_range(0, 9) < 6);
      in_a = a_arr[idx]; in_b = b_arr[idx];
      @(negedge clk);
      chk("pe_mode_hold", 64'(pe_mode), 64'(mode));
      if (in_valid && in_ready) begin
        idx++;
        if (idx == len) exp_rv = cyc + 6;
      end
      t++;
      if (t > 400) begin
        chk("feed_timeout", 64'(idx), 64'(len));
        in_valid = 0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 0; start = 0;
    if (rst_drain) begin
      @(posedge clk); #1; reset = 1;
      @(negedge clk);
      @(posedge clk); #1; reset = 0;
      @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pe_en", 64'(pe_en), 64'd0);
      chk("rst_res_valid", 64'(res_valid), 64'd0);
      return;
    end
    res_ready = stall == 0; sc = 0; guard = 0;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) break;
      if (res_valid) sc++;
      guard++;
      if (guard > 300) begin
        chk("result_timeout", 64'(res_valid), 64'd1);
        return;
      end
      @(posedge clk); #1;
      if (sc >= stall) res_ready = 1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy0", 64'(busy), 64'd0);
    chk("rst_in_ready0", 64'(in_ready), 64'd0);
    chk("rst_pe_en0", 64'(pe_en), 64'd0);
    chk("rst_res_valid0", 64'(res_valid), 64'd0);
    chk("rst_done0", 64'(done), 64'd0);
    chk("rst_pe_mode0", 64'(pe_mode), 64'd0);
    chk("rst_pe_ab0", 64'({pe_a, pe_b}), 64'd0);
    chk("rst_res_data0", 64'(res_data), 64'd0);

    for (int i = 0; i < 4; i++) begin a_arr[i] = {8'd3, 8'd2}; b_arr[i] = 8'd5; end
    run_job(0, 4, 0, 0, 0, 0);
    chk("t1_sum", 64'(res_data), 64'({16'd0, 20'd60, 20'd40}));

    for (int i = 0; i < 3; i++) begin a_arr[i] = {8'd10, 8'hFC}; b_arr[i] = 8'b01; end
    run_job(1, 3, 0, 0, 0, 0);
    chk("t2_lanes", 64'(res_data), 64'({14'd30, 14'h3FF4, 14'h3FE2, 14'd12}));

    fill(5);
    run_job(0, 5, 2, 4, 0, 0);
    run_job(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0);
    chk("t4_zero", 64'(res_data), 64'd0);
    fill(6);
    run_job(0, 6, 1, 1, 1, 0);
    fill(6);
    run_job(1, 6, 0, 0, 0, 0);
    fill(3);
    run_job(0, 3, 0, 0, 0, 1);
    fill(2);
    run_job(0, 2, 0, 2, 0, 0);

    for (int j = 0; j < 20; j++) begin
      int len;
      len = $urandom_range(1, 12);
      fill(len);
      run_job(1'($urandom_range(0, 1)), len, 1, $urandom_range(0, 3), 0, 0);
    end

    @(posedge clk); #1 res_ready = 0;
    repeat (6) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
